// File: rtl/alu_seq_display.sv
// alu_seq_display
//   Registered ALU with a start/done handshake, NZCV flags, a multi-cycle
//   shift-add unsigned multiply and a multiplexed 7-segment hex display of
//   the last completed result.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     operation request, sampled only while idle
//   a, b      operands (WIDTH bits)
//   op        operation select (3 bits)
//   busy      high while an operation is in flight
//   done      one-cycle pulse when result/flags update
//   result    registered result
//   zero, c_out, overflow, negative   flags, updated together with result
//   seg       active-low {dp,g,f,e,d,c,b,a}, dp always off
//   an        active-low one-hot digit enable
module alu_seq_display #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [2:0]        op,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              c_out,
  output logic              overflow,
  output logic              negative,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     a_reg, a_next;
  logic [WIDTH-1:0]     b_reg, b_next;
  logic [2:0]           op_reg, op_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [WIDTH-1:0]     result_reg, result_next;
  logic                 zero_reg, zero_next;
  logic                 c_reg, c_next;
  logic                 v_reg, v_next;
  logic                 n_reg, n_next;
  logic                 done_reg, done_next;

  // ---------------- single-cycle ALU on the latched operands ----------------
  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v;

  always_comb begin
    sum_w  = {1'b0, a_reg} + {1'b0, b_reg};
    diff_w = {1'b0, a_reg} + {1'b0, ~b_reg} + {{WIDTH{1'b0}}, 1'b1};
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (op_reg)
      OP_ADD: begin
        {alu_c, alu_r} = sum_w;
        alu_v = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                (sum_w[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry set means no borrow.
        {alu_c, alu_r} = diff_w;
        alu_v = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                (diff_w[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_AND: alu_r = a_reg & b_reg;
      OP_OR:  alu_r = a_reg | b_reg;
      OP_XOR: alu_r = a_reg ^ b_reg;
      OP_SHL: begin
        alu_r = {a_reg[WIDTH-2:0], 1'b0};
        alu_c = a_reg[WIDTH-1];
        alu_v = a_reg[WIDTH-1] ^ a_reg[WIDTH-2];
      end
      OP_SHR: begin
        alu_r = {1'b0, a_reg[WIDTH-1:1]};
        alu_c = a_reg[0];
      end
      default: alu_r = '0;
    endcase
  end

  // ---------------- shift-add multiply step ----------------
  logic [2*WIDTH-1:0] a_wide, mul_addend;
  logic [WIDTH-1:0]   b_shift;

  always_comb begin
    a_wide     = {{WIDTH{1'b0}}, a_reg};
    mul_addend = a_wide << count_reg;
    // Shift instead of indexing so count_reg may be one bit wider than an index.
    b_shift    = b_reg >> count_reg;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      count_reg  <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      c_reg      <= 1'b0;
      v_reg      <= 1'b0;
      n_reg      <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      count_reg  <= count_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      c_reg      <= c_next;
      v_reg      <= v_next;
      n_reg      <= n_next;
      done_reg   <= done_next;
    end
  end

  // ---------------- FSM: next state and datapath ----------------
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    count_next  = count_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    c_next      = c_reg;
    v_next      = v_reg;
    n_next      = n_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          op_next    = op;
          count_next = '0;
          acc_next   = '0;
          state_next = (op == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        result_next = alu_r;
        c_next      = alu_c;
        v_next      = alu_v;
        zero_next   = (alu_r == '0);
        n_next      = alu_r[WIDTH-1];
        done_next   = 1'b1;
        state_next  = IDLE;
      end
      MUL: begin
        if (count_reg == CW'(WIDTH)) begin
          // All WIDTH partial products accumulated; publish.
          result_next = acc_reg[WIDTH-1:0];
          c_next      = |acc_reg[2*WIDTH-1:WIDTH];
          v_next      = |acc_reg[2*WIDTH-1:WIDTH];
          zero_next   = (acc_reg[WIDTH-1:0] == '0);
          n_next      = acc_reg[WIDTH-1];
          done_next   = 1'b1;
          state_next  = IDLE;
        end else begin
          if (b_shift[0]) acc_next = acc_reg + mul_addend;
          count_next = count_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign result   = result_reg;
  assign zero     = zero_reg;
  assign c_out    = c_reg;
  assign overflow = v_reg;
  assign negative = n_reg;

  // ---------------- display scan ----------------
  logic [SW-1:0] scan_reg;
  logic [IW-1:0] digit_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_reg  <= '0;
      digit_reg <= '0;
    end else if (scan_reg == SW'(SCAN_DIV - 1)) begin
      scan_reg  <= '0;
      digit_reg <= (digit_reg == IW'(DIGITS - 1)) ? '0 : digit_reg + IW'(1);
    end else begin
      scan_reg <= scan_reg + SW'(1);
    end
  end

  // Result zero-padded out to a whole number of nibbles.
  logic [DIGITS*4-1:0] padded;
  for (genvar gi = 0; gi < DIGITS * 4; gi++) begin : g_pad
    if (gi < WIDTH) begin : g_bit
      assign padded[gi] = result_reg[gi];
    end else begin : g_zero
      assign padded[gi] = 1'b0;
    end
  end

  logic [3:0] nibble;
  always_comb begin
    nibble = padded[digit_reg*4 +: 4];
    an     = ~(DIGITS'(1) << digit_reg);
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
  end

endmodule
